// File: rtl/vvp_pkg.sv
// Shared mode encodings and width helper for the vvp dot-product lane.
// Optional clock-enable feature is selected by the VVP_CE_EN macro.
package vvp_pkg;

    localparam logic [1:0] VVP_PM1  = 2'b00;
    localparam logic [1:0] VVP_P1   = 2'b01;
    localparam logic [1:0] VVP_M1   = 2'b10;
    localparam logic [1:0] VVP_ZERO = 2'b11;

    // Width of a signed sum over n ternary products.
    function automatic int unsigned vvp_sw(input int unsigned n);
        return $clog2(n) + 2;
    endfunction

endpackage

// File: rtl/vvp_redux.sv
// Recursive reduction node: a size-1 node forms one ternary product, larger nodes add
// their upper-half (l) and lower-half (r) children. PIPE[level] adds an output register.
module vvp_redux
    import vvp_pkg::*;
#(
    parameter int unsigned         SZ   = 2,
    parameter logic [$clog2(SZ):0] PIPE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic [1:0]                   mode,
    input  logic [SZ-1:0]                W,
    input  logic [SZ-1:0]                D,
    output logic signed [$clog2(SZ)+1:0] S
);

    localparam int unsigned LV = $clog2(SZ);

    logic signed [LV+1:0] sum;

    if (SZ == 1) begin : g_leaf
        always_comb begin
            sum = '0;
            if (D[0]) begin
                unique case (mode)
                    VVP_PM1:  sum = W[0] ? 2'sb11 : 2'sb01;
                    VVP_P1:   sum = W[0] ? 2'sb01 : 2'sb00;
                    VVP_M1:   sum = W[0] ? 2'sb11 : 2'sb00;
                    VVP_ZERO: sum = 2'sb00;
                    default:  sum = 2'sb00;
                endcase
            end
        end
    end else begin : g_node
        localparam int unsigned HS = SZ / 2;

        logic signed [LV:0] sl;
        logic signed [LV:0] sr;

        vvp_redux #(
            .SZ   (HS),
            .PIPE (PIPE[LV-1:0])
        ) l (
            .clk  (clk),
            .rst  (rst),
            .ce   (ce),
            .mode (mode),
            .W    (W[SZ-1:HS]),
            .D    (D[SZ-1:HS]),
            .S    (sl)
        );

        vvp_redux #(
            .SZ   (HS),
            .PIPE (PIPE[LV-1:0])
        ) r (
            .clk  (clk),
            .rst  (rst),
            .ce   (ce),
            .mode (mode),
            .W    (W[HS-1:0]),
            .D    (D[HS-1:0]),
            .S    (sr)
        );

        assign sum = {sl[LV], sl} + {sr[LV], sr};
    end

    if (PIPE[LV]) begin : g_reg
        logic signed [LV+1:0] s_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                s_q <= '0;
            end else if (ce) begin
                s_q <= sum;
            end
        end

        assign S = s_q;
    end else begin : g_comb
        // Combinational levels never look at the control inputs.
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst, ce};
        assign S = sum;
    end

endmodule

// File: rtl/vvp_dot.sv
// Binary/ternary vector dot product with per-level pipelining selected by PIPE.
// Define VVP_CE_EN to add a clock-enable input 'ce' gating every pipeline register.
module vvp_dot
    import vvp_pkg::*;
#(
    parameter int unsigned        N    = 64,
    parameter logic [$clog2(N):0] PIPE = '0
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef VVP_CE_EN
    input  logic                     ce,
`endif
    input  logic [1:0]               mode,
    input  logic [N-1:0]             W,
    input  logic [N-1:0]             D,
    output logic signed [vvp_sw(N)-1:0] S
);

    logic ce_int;

`ifdef VVP_CE_EN
    assign ce_int = ce;
`else
    assign ce_int = 1'b1;
`endif

    vvp_redux #(
        .SZ   (N),
        .PIPE (PIPE)
    ) root (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce_int),
        .mode (mode),
        .W    (W),
        .D    (D),
        .S    (S)
    );

endmodule

// File: tb/tb_vvp_dot.sv
// Self-checking bench: a combinational and a 3-stage pipelined vvp_dot against a
// behavioural dot-product model with a 3-deep result delay line.
module tb_vvp_dot;

    localparam int unsigned N    = 64;
    localparam logic [6:0]  PIPE = 7'b0010101;
    localparam logic [63:0] ONES = '1;

    logic              clk = 1'b0;
    logic              rst;
    logic              ce;
    logic [1:0]        mode;
    logic [N-1:0]      W;
    logic [N-1:0]      D;
    logic signed [7:0] sc;
    logic signed [7:0] sp;

    int checks = 0;
    int errors = 0;

    int exp_q0 = 0;
    int exp_q1 = 0;
    int exp_q2 = 0;
    bit primed = 1'b0;

    always #5 clk = ~clk;

    vvp_dot #(
        .N    (N),
        .PIPE ('0)
    ) dut_c (
        .clk  (clk),
        .rst  (rst),
`ifdef VVP_CE_EN
        .ce   (ce),
`endif
        .mode (mode),
        .W    (W),
        .D    (D),
        .S    (sc)
    );

    vvp_dot #(
        .N    (N),
        .PIPE (PIPE)
    ) dut_p (
        .clk  (clk),
        .rst  (rst),
`ifdef VVP_CE_EN
        .ce   (ce),
`endif
        .mode (mode),
        .W    (W),
        .D    (D),
        .S    (sp)
    );

    function automatic int dot(input logic [1:0] m, input logic [63:0] w, input logic [63:0] d);
        int s = 0;
        for (int i = 0; i < 64; i++) begin
            if (d[i]) begin
                case (m)
                    2'b00:   s += w[i] ? -1 : 1;
                    2'b01:   s += w[i] ? 1 : 0;
                    2'b10:   s += w[i] ? -1 : 0;
                    default: s += 0;
                endcase
            end
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] m, input logic [63:0] w,
                        input logic [63:0] d);
        rst  = r;
        mode = m;
        W    = w;
        D    = d;
        @(posedge clk);
        #1;
    endtask

    // Reference: a reset flushes the whole delay line; each other edge shifts one result in.
    always @(posedge clk) begin
        if (rst) begin
            exp_q0 <= 0;
            exp_q1 <= 0;
            exp_q2 <= 0;
            primed <= 1'b1;
        end else begin
            exp_q0 <= dot(mode, W, D);
            exp_q1 <= exp_q0;
            exp_q2 <= exp_q1;
        end
    end

    always @(negedge clk) begin
        chk("comb_model", sc, dot(mode, W, D));
        if (primed) chk("pipe_model", sp, exp_q2);
    end

    initial begin
        logic [63:0] d;
        rst  = 1'b1;
        ce   = 1'b1;
        mode = 2'b00;
        W    = '0;
        D    = '0;
        step(1'b1, 2'b00, '0, '0);
        step(1'b1, 2'b00, '0, '0);

        // Combinational lane, hand-computed values.
        step(1'b0, 2'b00, '0, ONES);                    chk("c_pm1_w0", sc, 64);
        step(1'b0, 2'b00, ONES, ONES);                  chk("c_pm1_w1", sc, -64);
        step(1'b0, 2'b00, ONES, '0);                    chk("c_pm1_d0", sc, 0);
        step(1'b0, 2'b01, ONES, ONES);                  chk("c_p1_w1", sc, 64);
        step(1'b0, 2'b01, '0, ONES);                    chk("c_p1_w0", sc, 0);
        step(1'b0, 2'b10, ONES, ONES);                  chk("c_m1_w1", sc, -64);
        step(1'b0, 2'b10, '0, ONES);                    chk("c_m1_w0", sc, 0);
        step(1'b0, 2'b11, ONES, ONES);                  chk("c_zero", sc, 0);
        step(1'b0, 2'b00, 64'h5555_5555_5555_5555, ONES); chk("c_alt", sc, 0);
        step(1'b0, 2'b00, '0, 64'h0000_0000_0000_00FF);   chk("c_low8", sc, 8);

        step(1'b1, 2'b00, '0, '0);                      chk("p_reset", sp, 0);

        // Single vector through the pipeline: appears on the third edge.
        step(1'b0, 2'b00, '0, ONES);                    chk("p_lat_e1", sp, 0);
        step(1'b0, 2'b00, '0, '0);                      chk("p_lat_e2", sp, 0);
        step(1'b0, 2'b00, '0, '0);                      chk("p_lat_e3", sp, 64);
        step(1'b0, 2'b00, '0, '0);                      chk("p_lat_e4", sp, 0);

        // Back-to-back vectors.
        step(1'b0, 2'b00, '0, ONES);                    chk("p_b2b_e1", sp, 0);
        step(1'b0, 2'b00, ONES, ONES);                  chk("p_b2b_e2", sp, 0);
        step(1'b0, 2'b00, '0, '0);                      chk("p_b2b_e3", sp, 64);
        step(1'b0, 2'b00, '0, '0);                      chk("p_b2b_e4", sp, -64);
        step(1'b0, 2'b00, '0, '0);                      chk("p_b2b_e5", sp, 0);

        // Reset with two vectors in flight; neither may surface.
        step(1'b0, 2'b00, '0, ONES);                    chk("p_rst_e1", sp, 0);
        step(1'b0, 2'b00, ONES, ONES);                  chk("p_rst_e2", sp, 0);
        step(1'b1, 2'b00, '0, ONES);                    chk("p_rst_e3", sp, 0);
        step(1'b0, 2'b00, '0, '0);                      chk("p_rst_e4", sp, 0);
        step(1'b0, 2'b00, '0, '0);                      chk("p_rst_e5", sp, 0);
        step(1'b0, 2'b00, '0, '0);                      chk("p_rst_e6", sp, 0);

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       d = ONES;
                1:       d = {$urandom, $urandom} & {$urandom, $urandom};
                default: d = {$urandom, $urandom};
            endcase
            step(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, d);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vvp_dot.md
# vvp_dot

Binary/ternary vector-vector dot product with a configurable pipelined adder tree. Each of `n` 1-bit weights is mapped through a 2-bit `mode` to a value in {-1, 0, +1} and multiplied by a 1-bit data element in {0, 1}. The products are summed by a balanced binary reduction tree into a signed result. The block is the inner-product lane of the matrix-vector unit; pipelining is chosen per tree level by a mask parameter.

## Interface
- `N`, 64: vector length. Must be a power of two, at least 2.
- `PIPE`, 0: register mask, `$clog2(N)+1` bits. Bit k set places a register at the output of tree level k.
  - Level 0 is the per-element products; level `$clog2(N)` is the root sum.
  - PIPE = 0 gives a fully combinational block.
- `clk` input 1: clock; all registers update on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `mode` input 2: weight encoding, see Operation.
- `W` input N: weight bits.
- `D` input N: data bits, unsigned {0, 1} per element.
- `S` output `$clog2(N)+2`: signed dot product, two's complement.

## Operation
- Weight mapping for element i, with w = W[i]:
  - mode 00: w=0 → +1, w=1 → -1 (binary ±1).
  - mode 01: w=0 → 0, w=1 → +1.
  - mode 10: w=0 → 0, w=1 → -1.
  - mode 11: every weight → 0, so S = 0.
- Level-0 product: p[i] = weight(i) when D[i]=1, else 0. It is held in 2-bit signed form.
- Tree structure:
  - Level k+1 node = sign-extended sum of two level-k nodes.
  - Level k nodes are `k+2` bits wide; no overflow is possible.
  - Left child takes the upper half of the indices, right child the lower half.
- The result range is [-N, +N]. N=64 gives an 8-bit S.
- The full tree is evaluated from the current `mode`, `W` and `D`. Nothing is sampled separately.

## Timing
- Latency = popcount(PIPE) cycles. Example: PIPE = 7'b0010101 with N=64 gives 3 cycles.
- Throughput is one vector per cycle. There is no handshake and no stall.
- Unregistered levels are combinational within their cycle.
- Reset behaviour:
  - `rst`=1 at a rising edge clears every pipeline register to 0.
  - Registered S therefore reads 0 starting the cycle after that edge.
  - If level a is unregistered, S follows the cleared upstream registers.
- Reset mid-stream discards all in-flight partial sums.
- Inputs applied in the reset cycle are not captured.
- A fully combinational configuration ignores `rst`.

## Configuration
- `VVP_CE_EN` defined:
  - Adds input port `ce` (1 bit), placed after `rst`.
  - Pipeline registers load only when `ce`=1 and otherwise hold.
  - Reset has priority over `ce`.
- `VVP_CE_EN` undefined: there is no `ce` port and registers load every cycle.

## Structure
- Package `vvp_pkg` holds:
  - mode constants `VVP_PM1`=2'b00, `VVP_P1`=2'b01, `VVP_M1`=2'b10, `VVP_ZERO`=2'b11;
  - a function `vvp_sw(n)` returning `$clog2(n)+2`.
- Sub-module `vvp_redux`:
  - Recursive reduction node parameterised by size and by its PIPE slice.
  - A size-1 node computes and optionally registers the product.
  - Larger nodes instantiate `l` and `r` children and add their outputs. Each node exposes its output as `S`.

## Test plan
- PIPE=0, N=64, mode 00, D=all 1: W=0 → S=+64; W=all 1 → S=-64; D=0 → S=0.
- PIPE=0, mode 01: W=all 1, D=all 1 → +64; W=0 → 0. Mode 10: W=all 1, D=all 1 → -64; W=0 → 0.
- PIPE=0, mode 11, any W/D (all 1s) → 0. Mode 00, W=0x5555…, D=all 1 → 0. Mode 00, W=0, D=0x00FF… → +8.
- PIPE=7'b0010101, mode 00, W=0, D=all 1 for one cycle, then zeros → S=0, 0, 64 on the 3rd edge, then 0.
- Pipelined, back-to-back vectors giving +64, -64, 0 → same sequence on S, delayed by exactly 3 cycles.
- Pipelined, assert `rst` one cycle while data is in flight → S=0 after that edge; the in-flight vector never appears.
